// File: rtl/rf_load_sequencer.sv
// Register-file command sequencer: one LOAD32/INC/DEC/CLEAR per handshake, results built in place.
// Latency: LOAD32 done at T+NBYTES+1 (T+2 with short load), INC/DEC/CLEAR done at T+2; all outputs registered.
// Backpressure: cmd_ready high only in IDLE; option macro RF_SHORT_LOAD_EN enables one-cycle byte loads.
module rf_load_sequencer #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DEST_W-1:0] cmd_dest,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [2:0]        FunSel,
    output logic [3:0]        RegSel,
    output logic [3:0]        ScrSel,
    output logic [7:0]        I,
    output logic              busy,
    output logic              done
);
    localparam int NBYTES = DATA_W / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_INC   = 2'b01;
    localparam logic [1:0] OP_DEC   = 2'b10;

    localparam logic [2:0] FS_DEC   = 3'b000;
    localparam logic [2:0] FS_INC   = 3'b001;
    localparam logic [2:0] FS_LDB   = 3'b010;
    localparam logic [2:0] FS_CLR   = 3'b011;
    localparam logic [2:0] FS_SHIFT = 3'b110;

    typedef enum logic [1:0] {IDLE, SHIFT, OP, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [2:0]         fun_q, fun_d;
    logic [3:0]         reg_q, reg_d;
    logic [3:0]         scr_q, scr_d;
    logic [7:0]         i_q, i_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rdy_q, rdy_d;

    logic [3:0]         dest_reg, dest_scr;
    logic               short_ld;

`ifdef RF_SHORT_LOAD_EN
    assign short_ld = ((cmd_data >> 8) == '0);
`else
    assign short_ld = 1'b0;
`endif

    // Indices 0-3 address R1-R4, 4-7 address S1-S4; anything beyond selects nothing.
    always_comb begin
        dest_reg = 4'b0000;
        dest_scr = 4'b0000;
        if (32'(cmd_dest) < 32'd4)
            dest_reg[cmd_dest[1:0]] = 1'b1;
        else if (32'(cmd_dest) < 32'd8)
            dest_scr[cmd_dest[1:0]] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        fun_d   = fun_q;
        reg_d   = reg_q;
        scr_d   = scr_q;
        i_d     = i_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                fun_d = 3'b000;
                reg_d = 4'b0000;
                scr_d = 4'b0000;
                i_d   = 8'h00;
                if (rdy_q && cmd_valid) begin
                    reg_d   = dest_reg;
                    scr_d   = dest_scr;
                    state_d = OP;
                    case (cmd_op)
                        OP_LOAD: begin
                            if (short_ld) begin
                                fun_d = FS_LDB;
                                i_d   = cmd_data[7:0];
                            end else begin
                                state_d = SHIFT;
                                fun_d   = FS_SHIFT;
                                i_d     = cmd_data[DATA_W-1 -: 8];
                                data_d  = cmd_data << 8;
                                cnt_d   = CNT_W'(NBYTES - 1);
                            end
                        end
                        OP_INC:  fun_d = FS_INC;
                        OP_DEC:  fun_d = FS_DEC;
                        default: fun_d = FS_CLR;
                    endcase
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    fun_d   = 3'b000;
                    reg_d   = 4'b0000;
                    scr_d   = 4'b0000;
                    i_d     = 8'h00;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    i_d    = data_q[DATA_W-1 -: 8];
                    data_d = data_q << 8;
                end
            end
            OP: begin
                state_d = DONE;
                fun_d   = 3'b000;
                reg_d   = 4'b0000;
                scr_d   = 4'b0000;
                i_d     = 8'h00;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        rdy_d  = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            fun_q   <= 3'b000;
            reg_q   <= 4'b0000;
            scr_q   <= 4'b0000;
            i_q     <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            fun_q   <= fun_d;
            reg_q   <= reg_d;
            scr_q   <= scr_d;
            i_q     <= i_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdy_q   <= rdy_d;
        end
    end

    assign cmd_ready = rdy_q;
    assign FunSel    = fun_q;
    assign RegSel    = reg_q;
    assign ScrSel    = scr_q;
    assign I         = i_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_rf_load_sequencer.sv
// Bench for rf_load_sequencer: random commands, expected write cycles queued per command, a monitor pops and compares.
module tb_rf_load_sequencer;
    localparam int DATA_W = 32;
    localparam int DEST_W = 3;
    localparam int NBYTES = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'b00;
    logic [DEST_W-1:0] cmd_dest = '0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic [2:0]        FunSel;
    logic [3:0]        RegSel;
    logic [3:0]        ScrSel;
    logic [7:0]        I;
    logic              busy;
    logic              done;

    rf_load_sequencer #(.DATA_W(DATA_W), .DEST_W(DEST_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dest(cmd_dest), .cmd_data(cmd_data),
        .FunSel(FunSel), .RegSel(RegSel), .ScrSel(ScrSel), .I(I),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        bit         is_done;
        logic [2:0] fun;
        logic [3:0] rs;
        logic [3:0] ss;
        logic [7:0] i;
        int         dest;
        logic [31:0] val;
    } ev_t;

    ev_t         exp_q[$];
    int          vectors = 0;
    int          errors  = 0;
    int          edge_cnt = 0;
    int          next_ok = 0;
    bit          rf_loaded = 1'b0;
    logic [31:0] init_v[8];
    logic [31:0] rf[8];
    logic [31:0] ref_m[8];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Behavioural register file driven by the sequencer outputs.
    always @(posedge clk) begin
        logic [7:0] en_all;
        en_all = {ScrSel, RegSel};
        for (int r = 0; r < 8; r++) begin
            if (!rf_loaded) rf[r] <= init_v[r];
            else if (en_all[r]) begin
                case (FunSel)
                    3'b110:  rf[r] <= {rf[r][23:0], I};
                    3'b001:  rf[r] <= rf[r] + 32'd1;
                    3'b000:  rf[r] <= rf[r] - 32'd1;
                    3'b011:  rf[r] <= 32'd0;
                    3'b010:  rf[r] <= {24'd0, I};
                    default: ;
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic void push_ev(input int at, input bit is_done, input logic [2:0] f,
                                    input logic [7:0] ib, input int dest, input logic [31:0] val);
        ev_t e;
        e.at = at; e.is_done = is_done; e.fun = f; e.i = ib; e.dest = dest; e.val = val;
        e.rs = 4'b0000; e.ss = 4'b0000;
        if (!is_done) begin
            if (dest < 4) e.rs = 4'(1) << dest;
            else          e.ss = 4'(1) << (dest - 4);
        end
        exp_q.push_back(e);
    endfunction

    // Monitor: compares whatever the DUT presents in each cycle against the queue head.
    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            chk("reset_outputs", {17'd0, FunSel, RegSel, ScrSel, I, busy, done, cmd_ready}, 32'd0);
        end else begin
            while (exp_q.size() > 0 && exp_q[0].at < edge_cnt) begin
                chk("missed_event_edge", edge_cnt, exp_q[0].at);
                void'(exp_q.pop_front());
            end
            if (busy) chk("ready_while_busy", cmd_ready, 0);
            if (exp_q.size() > 0 && exp_q[0].at == edge_cnt) begin
                e = exp_q.pop_front();
                if (e.is_done) begin
                    chk("done_pulse", done, 1);
                    chk("done_enables", {RegSel, ScrSel}, 0);
                    chk("done_busy", busy, 1);
                    chk("result_value", rf[e.dest], e.val);
                end else begin
                    chk("write_funsel", FunSel, e.fun);
                    chk("write_regsel", RegSel, e.rs);
                    chk("write_scrsel", ScrSel, e.ss);
                    chk("write_ibyte", I, e.i);
                    chk("write_busy_done", {busy, done}, 2'b10);
                end
            end else begin
                chk("quiet_cycle", {RegSel, ScrSel, done}, 0);
            end
        end
    end

    // Issue one command (caller sits at a negedge); returns one negedge after acceptance.
    task automatic send(input logic [1:0] op, input int dest, input logic [31:0] data, input bit b2b);
        int waitc;
        int t;
        int d_at;
        waitc = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_dest = dest[DEST_W-1:0]; cmd_data = data;
        while (!cmd_ready) begin
            @(negedge clk);
            waitc++;
            if (waitc > 100) begin
                chk("accept_timeout", cmd_ready, 1);
                cmd_valid = 1'b0;
                return;
            end
        end
        t = edge_cnt + 1;
        if (b2b) chk("accept_edge", t, next_ok);
        d_at = t + 1;
        case (op)
            2'b00: begin
`ifdef RF_SHORT_LOAD_EN
                if (data[31:8] == 24'd0) begin
                    push_ev(t, 1'b0, 3'b010, data[7:0], dest, 0);
                end else
`endif
                begin
                    for (int k = 0; k < NBYTES; k++)
                        push_ev(t + k, 1'b0, 3'b110, data[8*(NBYTES-1-k) +: 8], dest, 0);
                    d_at = t + NBYTES;
                end
                ref_m[dest] = data;
            end
            2'b01: begin push_ev(t, 1'b0, 3'b001, 8'h00, dest, 0); ref_m[dest] = ref_m[dest] + 1; end
            2'b10: begin push_ev(t, 1'b0, 3'b000, 8'h00, dest, 0); ref_m[dest] = ref_m[dest] - 1; end
            default: begin push_ev(t, 1'b0, 3'b011, 8'h00, dest, 0); ref_m[dest] = 32'd0; end
        endcase
        push_ev(d_at, 1'b1, 3'b000, 8'h00, dest, ref_m[dest]);
        next_ok = d_at + 2;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || !cmd_ready) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        logic [31:0] old;
        for (int r = 0; r < 8; r++) begin
            init_v[r] = $urandom;
            ref_m[r]  = init_v[r];
        end
        repeat (3) @(negedge clk);
        rf_loaded = 1'b1;
        rst = 1'b1;
        chk("ready_low_after_release", cmd_ready, 0);
        @(negedge clk);
        chk("ready_high_idle", cmd_ready, 1);

        send(2'b00, 1, 32'h12345678, 1'b0);
        send(2'b00, 0, 32'h000000A5, 1'b1);
        send(2'b01, 6, 32'h0, 1'b1);
        send(2'b11, 4, 32'h0, 1'b1);
        send(2'b10, 4, 32'h0, 1'b1);

        repeat (150) begin
            int gap;
            logic [31:0] d;
            d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            gap = $urandom_range(0, 2);
            if (gap > 0) repeat (gap) @(negedge clk);
            send(2'($urandom_range(0, 3)), $urandom_range(0, 7), d, gap == 0);
        end
        drain();

        // Abort a LOAD32 after two bytes have been written.
        old = ref_m[5];
        send(2'b00, 5, 32'hDEADBEEF, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        #1;
        chk("async_reset_outputs", {FunSel, RegSel, ScrSel, I, busy, done, cmd_ready}, 0);
        ref_m[5] = {old[15:0], 16'hDEAD};
        repeat (2) @(negedge clk);
        chk("partial_load_kept", rf[5], ref_m[5]);
        rst = 1'b1;
        chk("ready_low_after_abort", cmd_ready, 0);
        @(negedge clk);
        chk("ready_high_after_abort", cmd_ready, 1);
        send(2'b11, 3, 32'h0, 1'b0);
        drain();
        chk("r4_cleared", rf[3], 32'd0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
